vram_arbiter: RTL and testbench

- Shares one single-port synchronous video RAM between two requesters: the VGA scanout path and a CPU-side request/ack port.
- Scanout is driven by the column/rgb_en outputs of hsync_cnt and a row count from the vertical counter.
- The framebuffer is 160x120 at 8 bpp, so each stored pixel covers a 4x4 block of the 640x480 screen.
- Scanout has fixed priority on its fetch slots. The CPU gets every other memory cycle, with no starvation.

---
 rtl/vram_arbiter_if.sv | 34 +++
 rtl/vram_arbiter.sv | 120 ++++++++++++
 tb/tb_vram_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// CPU request/ack channel plus the single-port video RAM bus.
// The arbiter takes the slave view; the requester/RAM environment takes the master view.
// The CPU holds req/we/addr/wdata stable until ack; the RAM answers reads one cycle after issue.
interface vram_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Requester and RAM side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Shares one single-port video RAM between VGA scanout (fixed-priority slots) and a CPU port.
// Latency: pixel/pixel_valid trail column/rgb_en by 2 cycles; a CPU access acks 1 cycle after issue.
// Backpressure: a CPU request that lands on a display slot stalls in IDLE for one cycle.
module vram_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int FB_WIDTH = H_ACTIVE / 4,
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rgb_en,
  input  logic [9:0]        column,
  input  logic [9:0]        row,
  vram_arbiter_if.slave     bus,
  output logic [DATA_W-1:0] pixel,
  output logic              pixel_valid
);

  typedef enum logic {IDLE, DONE} state_t;

  state_t            r_state;
  logic              r_cpu_we;      // direction of the access currently in flight
  logic              r_tag_disp;    // 1 = previous cycle's RAM read belonged to scanout
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_pix;
  logic              r_en_d1;
  logic              r_en_d2;

  logic [7:0]        w_row_blk;
  logic [7:0]        w_col_blk;
  logic [ADDR_W-1:0] w_disp_addr;
  logic              w_disp_slot;
  logic              w_cpu_issue;
  logic              w_cpu_return;

  // Each stored pixel covers a 4x4 screen block.
  assign w_row_blk = row[9:2];
  assign w_col_blk = column[9:2];

  // A 160-word row stride is 128+32, so the row multiply collapses to two shifts and an add.
  if (FB_WIDTH == 160) begin : g_shift_add
    assign w_disp_addr = ADDR_W'({w_row_blk, 7'b0}) + ADDR_W'({w_row_blk, 5'b0})
                       + ADDR_W'(w_col_blk);
  end else begin : g_mul
    assign w_disp_addr = ADDR_W'(w_row_blk * FB_WIDTH) + ADDR_W'(w_col_blk);
  end

  // Scanout fetches once per 4-column block; the CPU only issues from IDLE on non-slot cycles.
  assign w_disp_slot  = rgb_en && (column[1:0] == 2'b00) && (row < 10'(V_ACTIVE));
  assign w_cpu_issue  = (r_state == IDLE) && bus.cpu_req && !w_disp_slot;
  assign w_cpu_return = (r_state == DONE) && !r_tag_disp && !r_cpu_we;

  // Per-cycle port ownership: display slot first, then an issuing CPU, otherwise parked at 0.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    if (w_disp_slot) begin
      bus.mem_addr = w_disp_addr;
    end else if (w_cpu_issue) begin
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_we    = bus.cpu_we && !rst;
      bus.mem_wdata = bus.cpu_wdata;
    end
  end

  // CPU FSM: issue from IDLE, ack in DONE, always fall back to IDLE without sampling cpu_req.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cpu_we <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cpu_issue) begin
            r_state  <= DONE;
            r_cpu_we <= bus.cpu_we;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read-return tag and scanout pipeline: latch the fetched pixel and delay rgb_en to match.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_disp <= 1'b0;
      r_pix      <= '0;
      r_en_d1    <= 1'b0;
      r_en_d2    <= 1'b0;
    end else begin
      r_tag_disp <= w_disp_slot;
      if (r_tag_disp) begin
        r_pix <= bus.mem_rdata;
      end
      r_en_d1 <= rgb_en;
      r_en_d2 <= r_en_d1;
    end
  end

  // Hold the last CPU read value so writes leave cpu_rdata unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpu_rdata <= '0;
    end else if (w_cpu_return) begin
      r_cpu_rdata <= bus.mem_rdata;
    end
  end

  // Reset kills an in-flight ack immediately; read data is passed straight through in DONE.
  assign bus.cpu_ack   = (r_state == DONE) && !rst;
  assign bus.cpu_rdata = (w_cpu_return && !rst) ? bus.mem_rdata : r_cpu_rdata;
  assign pixel_valid   = r_en_d2;
  assign pixel         = r_en_d2 ? r_pix : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: vector table for reset/blanking/scanout/boundaries,
// plus hand-written collision, back-to-back and reset-mid-access sequences.
// A behavioural RAM (read-first, 1-cycle latency, RAM[k]=k[7:0]) sits on the memory bus.
module tb_vram_arbiter;

  logic       clk;
  logic       rst;
  logic       rgb_en;
  logic [9:0] column;
  logic [9:0] row;
  logic [7:0] pixel;
  logic       pixel_valid;

  int checks   = 0;
  int failures = 0;

  vram_arbiter_if #(.ADDR_W(15), .DATA_W(8)) bus ();

  vram_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .rgb_en      (rgb_en),
    .column      (column),
    .row         (row),
    .bus         (bus),
    .pixel       (pixel),
    .pixel_valid (pixel_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM, preloaded on the first edge.
  logic [7:0] ram [0:19199];
  logic       ram_loaded = 1'b0;

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int k = 0; k < 19200; k++) ram[k] <= 8'(k);
      ram_loaded    <= 1'b1;
      bus.mem_rdata <= 8'h00;
    end else if (bus.mem_addr < 15'd19200) begin
      bus.mem_rdata <= ram[bus.mem_addr];
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    end else begin
      bus.mem_rdata <= 8'h00;
    end
  end

  typedef struct {
    logic        rst;
    logic        en;
    logic [9:0]  col;
    logic [9:0]  row;
    logic        req;
    logic        we;
    logic [14:0] addr;
    logic [7:0]  wd;
    logic        e_we;
    logic [14:0] e_addr;
    logic        e_ack;
    logic [7:0]  e_rdata;
    logic [7:0]  e_pix;
    logic        e_pv;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic en, logic [9:0] col, logic [9:0] rw,
                              logic req, logic we, logic [14:0] addr, logic [7:0] wd,
                              logic e_we, logic [14:0] e_addr, logic e_ack,
                              logic [7:0] e_rdata, logic [7:0] e_pix, logic e_pv);
    vec_t v;
    v.rst = r; v.en = en; v.col = col; v.row = rw; v.req = req; v.we = we;
    v.addr = addr; v.wd = wd; v.e_we = e_we; v.e_addr = e_addr; v.e_ack = e_ack;
    v.e_rdata = e_rdata; v.e_pix = e_pix; v.e_pv = e_pv;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  // One clock cycle: inputs change just after the rising edge, outputs sampled at the falling edge.
  task automatic drive(input logic r, input logic en, input logic [9:0] col, input logic [9:0] rw,
                       input logic req, input logic we, input logic [14:0] addr, input logic [7:0] wd);
    @(posedge clk);
    #1;
    rst = r; rgb_en = en; column = col; row = rw;
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
    @(negedge clk);
  endtask

  initial begin
    int  acks;
    logic prev_ack;

    rst = 1'b1; rgb_en = 1'b0; column = '0; row = '0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 15'h1234; bus.cpu_wdata = 8'hA5;

    // Reset held with a write request pending: nothing may reach the RAM or the CPU.
    vecs.push_back(mk(1,0,0,0, 1,1,15'h1234,8'hA5, 0,15'h1234,0,8'h00,8'h00,0));
    vecs.push_back(mk(1,0,0,0, 1,1,15'h1234,8'hA5, 0,15'h1234,0,8'h00,8'h00,0));
    // Blanking write 0x1234 <= 0xA5, then read it back.
    vecs.push_back(mk(0,0,0,0, 1,1,15'h1234,8'hA5, 1,15'h1234,0,8'h00,8'h00,0));
    vecs.push_back(mk(0,0,0,0, 1,1,15'h1234,8'hA5, 0,15'h0000,1,8'h00,8'h00,0));
    vecs.push_back(mk(0,0,0,0, 1,0,15'h1234,8'h00, 0,15'h1234,0,8'h00,8'h00,0));
    vecs.push_back(mk(0,0,0,0, 1,0,15'h1234,8'h00, 0,15'h0000,1,8'hA5,8'h00,0));
    vecs.push_back(mk(0,0,0,0, 0,0,15'h0000,8'h00, 0,15'h0000,0,8'hA5,8'h00,0));
    // Scanout of row 8 (block row 2 -> base 320), columns 0..15.
    for (int c = 0; c < 16; c++) begin
      vecs.push_back(mk(0,1,10'(c),10'd8, 0,0,15'h0000,8'h00,
                        0, (c % 4 == 0) ? 15'(320 + c / 4) : 15'h0000, 0, 8'hA5,
                        (c >= 2) ? 8'(8'h40 + ((c - 2) >> 2)) : 8'h00, (c >= 2)));
    end
    // Pipeline drains two cycles after rgb_en drops.
    vecs.push_back(mk(0,0,0,8, 0,0,15'h0000,8'h00, 0,15'h0000,0,8'hA5,8'h43,1));
    vecs.push_back(mk(0,0,0,8, 0,0,15'h0000,8'h00, 0,15'h0000,0,8'hA5,8'h43,1));
    vecs.push_back(mk(0,0,0,8, 0,0,15'h0000,8'h00, 0,15'h0000,0,8'hA5,8'h00,0));
    // Last fetch of the frame (row 479, column 636 -> 19199), then row 480 gives no slot.
    vecs.push_back(mk(0,1,636,479, 0,0,15'h0000,8'h00, 0,15'd19199,0,8'hA5,8'h00,0));
    vecs.push_back(mk(0,1,637,479, 0,0,15'h0000,8'h00, 0,15'h0000,0,8'hA5,8'h00,0));
    vecs.push_back(mk(0,1,0,480,   0,0,15'h0000,8'h00, 0,15'h0000,0,8'hA5,8'hFF,1));
    vecs.push_back(mk(0,0,0,0,     0,0,15'h0000,8'h00, 0,15'h0000,0,8'hA5,8'hFF,1));
    vecs.push_back(mk(0,0,0,0,     0,0,15'h0000,8'h00, 0,15'h0000,0,8'hA5,8'hFF,1));
    vecs.push_back(mk(0,0,0,0,     0,0,15'h0000,8'h00, 0,15'h0000,0,8'hA5,8'h00,0));

    // Power-on cycle so every register has seen reset before the first checked vector.
    drive(1,0,0,0, 1,1,15'h1234,8'hA5);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].col, vecs[i].row,
            vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wd);
      chk("mem_we",      i, 32'(bus.mem_we),    32'(vecs[i].e_we));
      chk("mem_addr",    i, 32'(bus.mem_addr),  32'(vecs[i].e_addr));
      chk("cpu_ack",     i, 32'(bus.cpu_ack),   32'(vecs[i].e_ack));
      chk("cpu_rdata",   i, 32'(bus.cpu_rdata), 32'(vecs[i].e_rdata));
      chk("pixel",       i, 32'(pixel),         32'(vecs[i].e_pix));
      chk("pixel_valid", i, 32'(pixel_valid),   32'(vecs[i].e_pv));
    end

    // Collision: CPU read of 0x1234 raised on column 4 of active row 8.
    for (int c = 0; c < 14; c++) begin
      drive(0, 1, 10'(c), 10'd8, (c >= 4 && c <= 6), 0, 15'h1234, 8'h00);
      if (c == 4) begin
        chk("coll_disp_addr", c, 32'(bus.mem_addr), 32'd321);
        chk("coll_stall_ack", c, 32'(bus.cpu_ack),  32'd0);
      end
      if (c == 5) begin
        chk("coll_cpu_addr", c, 32'(bus.mem_addr), 32'h1234);
        chk("coll_cpu_we",   c, 32'(bus.mem_we),   32'd0);
        chk("coll_no_ack",   c, 32'(bus.cpu_ack),  32'd0);
      end
      if (c == 6) begin
        chk("coll_ack",   c, 32'(bus.cpu_ack),   32'd1);
        chk("coll_rdata", c, 32'(bus.cpu_rdata), 32'hA5);
      end
      if (c == 7) chk("coll_ack_drop", c, 32'(bus.cpu_ack), 32'd0);
      if (c >= 2) begin
        chk("coll_pixel", c, 32'(pixel),       32'(8'h40 + ((c - 2) >> 2)));
        chk("coll_pv",    c, 32'(pixel_valid), 32'd1);
      end
    end
    drive(0,0,0,0, 0,0,15'h0000,8'h00);
    drive(0,0,0,0, 0,0,15'h0000,8'h00);

    // Back-to-back: request held for 10 blanking cycles -> ack every other cycle.
    acks = 0;
    prev_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(0,0,0,0, 1,1,15'h0100,8'h11);
      chk("b2b_ack",    i, 32'(bus.cpu_ack), 32'(i % 2 == 1));
      chk("b2b_mem_we", i, 32'(bus.mem_we),  32'(i % 2 == 0));
      if (bus.cpu_ack) acks++;
      if (prev_ack && bus.cpu_ack) begin
        failures++;
        $display("FAIL b2b_consecutive_ack step=%0d got=1 want=0", i);
      end
      prev_ack = bus.cpu_ack;
    end
    chk("b2b_ack_count", 0, 32'(acks), 32'd5);
    drive(0,0,0,0, 0,0,15'h0000,8'h00);

    // Reset lands on the DONE cycle of a write: no ack, then a fresh read completes normally.
    drive(0,0,0,0, 1,1,15'h0200,8'h77);
    chk("rst_mid_issue_we", 0, 32'(bus.mem_we), 32'd1);
    drive(1,0,0,0, 1,1,15'h0200,8'h77);
    chk("rst_mid_no_ack",   1, 32'(bus.cpu_ack), 32'd0);
    chk("rst_mid_no_we",    1, 32'(bus.mem_we),  32'd0);
    drive(0,0,0,0, 1,0,15'h0200,8'h00);
    chk("rst_mid_reissue_addr", 2, 32'(bus.mem_addr),  32'h0200);
    chk("rst_mid_reissue_we",   2, 32'(bus.mem_we),    32'd0);
    chk("rst_mid_reissue_ack",  2, 32'(bus.cpu_ack),   32'd0);
    chk("rst_mid_rdata_clear",  2, 32'(bus.cpu_rdata), 32'd0);
    drive(0,0,0,0, 1,0,15'h0200,8'h00);
    chk("rst_mid_ack",   3, 32'(bus.cpu_ack),   32'd1);
    chk("rst_mid_rdata", 3, 32'(bus.cpu_rdata), 32'h77);
    drive(0,0,0,0, 0,0,15'h0000,8'h00);
    chk("rst_mid_ack_drop", 4, 32'(bus.cpu_ack), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
